ram_port_arbiter: RTL
=====================

# ram_port_arbiter

Shares the single read/write port (port A) of the synchronous block RAM between three requesters: instruction fetch (if), load/store (ls) and the memory-mapped I/O/debug engine (io). It sits between the CPU control FSM, the load/store address path and the RAM. It serialises accesses, applies fixed priority with a starvation guard for io, and returns read data with a per-requester valid strobe.

## Interface
Parameters:
- DATA_W, 16: RAM word width.
- ADDR_W, 10: RAM address width.
- STARVE_MAX, 8: waiting cycles after which io is forced to win. Legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req, ls_req, io_req  in  1 each  access request. Hold high with address, we and wdata stable until the matching gnt.
- if_we, ls_we, io_we  in  1 each  1 = write, 0 = read.
- if_addr, ls_addr, io_addr  in  ADDR_W each  word address.
- if_wdata, ls_wdata, io_wdata  in  DATA_W each  write data.
- if_gnt, ls_gnt, io_gnt  out  1 each  one-cycle pulse; the access is issued to the RAM in this cycle.
- if_rvalid, ls_rvalid, io_rvalid  out  1 each  one-cycle pulse; rdata is valid for this requester.
- rdata  out  DATA_W  shared read data bus.
- ram_en  out  1  RAM port A enable.
- ram_we  out  1  RAM port A write enable.
- ram_addr  out  ADDR_W  RAM port A address.
- ram_din  out  DATA_W  RAM port A write data.
- ram_dout  in  DATA_W  RAM port A read data, valid one cycle after the read is issued.

## Operation
- States:
  - IDLE: no access in flight.
  - ACCESS: RAM port driven; gnt high for the owner.
  - READ: ram_dout valid; rvalid high for the owner.
- Winner selection among eligible requests:
  - io wins if its starvation counter has reached STARVE_MAX.
  - Otherwise priority is ls > if > io.
- Eligible requests:
  - In IDLE and READ: all active requests.
  - In ACCESS: all active requests except the current owner. Its req is still high that cycle.
- Transitions:
  - IDLE → ACCESS if any request is eligible; otherwise stay in IDLE.
  - ACCESS (write) → ACCESS with the new winner if any request is eligible, otherwise IDLE.
  - ACCESS (read) → READ unconditionally.
  - READ → ACCESS with the new winner if any request is eligible, otherwise IDLE.
- On entry to ACCESS, the following are registered: owner (2-bit), ram_en = 1, ram_we = the owner's we, ram_addr, ram_din. gnt is decoded from state == ACCESS and the owner.
- In READ: rdata = ram_dout (combinational pass-through), and the owner's rvalid = 1.
  - rdata is don't-care outside READ; drive it to 0.
- Starvation counter:
  - Increments each cycle io_req = 1 and io_gnt = 0.
  - Saturates at STARVE_MAX.
  - Clears on io_gnt or when io_req = 0.
- Requesters must drop req in the cycle after their gnt.
  - If req is still high in the following arbitration cycle, it counts as a new request.
- Reset behaviour:
  - All outputs are 0, state is IDLE, owner = if, counter = 0.
  - Reset asserted mid-read cancels the read: no rvalid is ever issued, and the requester must re-request.

## Timing
- Request sampled at rising edge k in IDLE → gnt and RAM drive during cycle k+1.
- Write: the RAM captures the write at edge k+2. Total occupancy is 1 cycle.
- Read: rvalid and rdata during cycle k+2. Total occupancy is 2 cycles.
- No idle bubble between back-to-back accesses:
  - Write-to-next-access: the next gnt follows in the next cycle.
  - Read-to-next-access: the next gnt arrives in the cycle after rvalid.
- There is never more than one access outstanding. At most one gnt and at most one rvalid are high per cycle.
- ram_en, ram_we, ram_addr and ram_din are registered outputs. gnt and rvalid are decoded from registered state only; there is no combinational path from any req to them.
- ram_en = 0 and ram_we = 0 in IDLE and READ.

## Test plan
- **Single read:** if_req = 1, if_we = 0, if_addr = 0x005 (RAM[5] = 0xBEEF).
  - Required: if_gnt in cycle 1, ram_en = 1, ram_addr = 0x005, ram_we = 0.
  - Required: if_rvalid = 1 and rdata = 0xBEEF in cycle 2; then IDLE.
- **Priority:** ls_req (write 0x1234 to 0x010) and if_req (read 0x000) raised in the same cycle.
  - Required: ls_gnt first, if_gnt in the very next cycle, RAM[0x010] = 0x1234, and if_rvalid one cycle later.
- **Back-to-back reads:** ls read 0x020, followed by if read 0x021 held pending.
  - Required: rvalid for ls, then if_gnt the next cycle, with no IDLE cycle between the accesses.
- **Starvation:** STARVE_MAX = 4; io_req held high while ls and if re-request continuously with writes.
  - Required: io_gnt within 5 cycles of io_req rising; counter returns to 0 after io_gnt.
- **Reset mid-read:** reset pulled low during READ of 0x030.
  - Required: all gnt, rvalid and ram_* outputs are 0 immediately (asynchronous); no rvalid after release; a fresh request is then granted normally.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares RAM port A between instruction fetch (if),
// load/store (ls) and the I/O/debug engine (io). One access is in flight at a
// time; ls > if > io fixed priority, except io is forced through once it has
// waited STARVE_MAX cycles. Reads return data one cycle after the grant.
module ram_port_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic              ls_req,
  input  logic              io_req,
  input  logic              if_we,
  input  logic              ls_we,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] if_wdata,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              if_gnt,
  output logic              ls_gnt,
  output logic              io_gnt,
  output logic              if_rvalid,
  output logic              ls_rvalid,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_READ   = 2'd2
  } state_t;

  localparam logic [1:0] OWN_IF = 2'd0;
  localparam logic [1:0] OWN_LS = 2'd1;
  localparam logic [1:0] OWN_IO = 2'd2;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  state_t              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic [7:0]          starve_q, starve_d;

  logic [2:0]          req_vec;
  logic [2:0]          owner_mask;
  logic [2:0]          eligible;
  logic [1:0]          winner;

  // Request vector bit order: [2]=io, [1]=ls, [0]=if.
  assign req_vec = {io_req, ls_req, if_req};

  // Work out who may compete this cycle and who wins; the current owner is
  // excluded during its own grant cycle because its req is still high then.
  always_comb begin
    owner_mask = 3'b000;
    eligible   = 3'b000;
    winner     = OWN_IO;
    case (owner_q)
      OWN_IF:  owner_mask = 3'b001;
      OWN_LS:  owner_mask = 3'b010;
      OWN_IO:  owner_mask = 3'b100;
      default: owner_mask = 3'b000;
    endcase
    if (state_q == ST_ACCESS) begin
      eligible = req_vec & ~owner_mask;
    end else begin
      eligible = req_vec;
    end
    if (eligible[2] && (starve_q == STARVE_LIM)) begin
      winner = OWN_IO;
    end else if (eligible[1]) begin
      winner = OWN_LS;
    end else if (eligible[0]) begin
      winner = OWN_IF;
    end else begin
      winner = OWN_IO;
    end
  end

  // Next-state logic: issue a new access whenever the port is free and someone
  // is eligible; a read always spends one extra cycle in READ for the data.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ram_en_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    case (state_q)
      ST_IDLE, ST_READ: begin
        state_d = ST_IDLE;
        if (|eligible) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!ram_we_q) begin
          state_d = ST_READ;
        end else if (|eligible) begin
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_d == ST_ACCESS) && (|eligible)) begin
      owner_d  = winner;
      ram_en_d = 1'b1;
      case (winner)
        OWN_IF: begin
          ram_we_d   = if_we;
          ram_addr_d = if_addr;
          ram_din_d  = if_wdata;
        end
        OWN_LS: begin
          ram_we_d   = ls_we;
          ram_addr_d = ls_addr;
          ram_din_d  = ls_wdata;
        end
        default: begin
          ram_we_d   = io_we;
          ram_addr_d = io_addr;
          ram_din_d  = io_wdata;
        end
      endcase
    end
  end

  // Starvation counter: counts cycles io waits, saturating, cleared on grant
  // or when io withdraws its request.
  always_comb begin
    starve_d = 8'd0;
    if (io_req && !io_gnt) begin
      if (starve_q == STARVE_LIM) begin
        starve_d = starve_q;
      end else begin
        starve_d = starve_q + 8'd1;
      end
    end
  end

  // State and RAM-port registers; reset cancels any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      starve_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      starve_q   <= starve_d;
    end
  end

  assign if_gnt    = (state_q == ST_ACCESS) && (owner_q == OWN_IF);
  assign ls_gnt    = (state_q == ST_ACCESS) && (owner_q == OWN_LS);
  assign io_gnt    = (state_q == ST_ACCESS) && (owner_q == OWN_IO);
  assign if_rvalid = (state_q == ST_READ) && (owner_q == OWN_IF);
  assign ls_rvalid = (state_q == ST_READ) && (owner_q == OWN_LS);
  assign io_rvalid = (state_q == ST_READ) && (owner_q == OWN_IO);
  assign rdata     = (state_q == ST_READ) ? ram_dout : '0;

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;

endmodule
